output_vc_credit_tracker: RTL



---
 rtl/output_vc_credit_tracker_pkg.sv | 7 +
 rtl/ovc_credit_cell.sv | 64 ++++++
 rtl/output_vc_credit_tracker.sv | 46 ++++
 3 files changed

// File: rtl/output_vc_credit_tracker_pkg.sv
// output_vc_credit_tracker_pkg: OVC state encoding and credit counter width helper.
package output_vc_credit_tracker_pkg;
  typedef enum logic [1:0] {OVC_IDLE, OVC_ACTIVE, OVC_DRAIN} ovc_state_t;
  function automatic int cw_of(input int b);
    return $clog2(b + 1);
  endfunction
endpackage

// File: rtl/ovc_credit_cell.sv
// ovc_credit_cell: one output VC ownership FSM plus its downstream credit counter.
module ovc_credit_cell
  import output_vc_credit_tracker_pkg::*;
#(
  parameter int B = 4,
  parameter int CW = 3,
  parameter bit ATOMIC = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alloc,
  input  logic          sent,
  input  logic          tail,
  input  logic          credit,
  output logic          avail,
  output logic          full,
  output logic          nearly_full,
  output logic [CW-1:0] cnt,
  output logic          err_uf,
  output logic          err_of,
  output logic          err_ill
);
  localparam logic [CW-1:0] FULL_CNT = CW'(B);
  ovc_state_t st, st_nxt;
  logic [CW-1:0] cnt_nxt;
  logic tail_sent;
  assign tail_sent = sent & tail;
  always_comb begin
    err_uf = sent & ~credit & (cnt == '0);
    err_of = credit & ~sent & (cnt == FULL_CNT);
    cnt_nxt = (sent & ~credit) ? (err_uf ? cnt : cnt - 1'b1) :
              (credit & ~sent) ? (err_of ? cnt : cnt + 1'b1) : cnt;
    st_nxt = st;
    err_ill = 1'b0;
    case (st)
      OVC_IDLE: begin
        st_nxt = !alloc ? OVC_IDLE : !tail_sent ? OVC_ACTIVE : ATOMIC ? OVC_DRAIN : OVC_IDLE;
        err_ill = sent & ~alloc;
      end
      OVC_ACTIVE: begin
        st_nxt = !tail_sent ? OVC_ACTIVE : ATOMIC ? OVC_DRAIN : OVC_IDLE;
        err_ill = alloc;
      end
      OVC_DRAIN: begin
        // released on the edge that brings the last credit home
        st_nxt = (cnt_nxt == FULL_CNT) ? OVC_IDLE : OVC_DRAIN;
        err_ill = alloc;
      end
      default: st_nxt = OVC_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st <= OVC_IDLE;
      cnt <= FULL_CNT;
    end else begin
      st <= st_nxt;
      cnt <= cnt_nxt;
    end
  end
  assign avail = (st == OVC_IDLE);
  assign full = (cnt == '0);
  assign nearly_full = (cnt == CW'(1));
endmodule

// File: rtl/output_vc_credit_tracker.sv
// output_vc_credit_tracker: per-output-port OVC ownership and downstream credit tracking.
module output_vc_credit_tracker
  import output_vc_credit_tracker_pkg::*;
#(
  parameter int V = 4,
  parameter int B = 4,
  parameter string VC_REALLOC_TYPE = "NONATOMIC",
  localparam int CW = cw_of(B)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [V-1:0]    ovc_alloc,
  input  logic            flit_sent,
  input  logic [V-1:0]    flit_sent_ovc,
  input  logic            flit_sent_tail,
  input  logic [V-1:0]    credit_in,
  output logic [V-1:0]    ovc_avail,
  output logic [V-1:0]    ovc_full,
  output logic [V-1:0]    ovc_nearly_full,
  output logic [V*CW-1:0] credit_cnt_all,
  output logic [2:0]      err
);
  localparam bit ATOMIC = (VC_REALLOC_TYPE == "ATOMIC");
  logic [V-1:0] uf, of, ill;
  for (genvar i = 0; i < V; i++) begin : g_ovc
    ovc_credit_cell #(.B(B), .CW(CW), .ATOMIC(ATOMIC)) u_cell (
      .clk         (clk),
      .reset       (reset),
      .alloc       (ovc_alloc[i]),
      .sent        (flit_sent & flit_sent_ovc[i]),
      .tail        (flit_sent_tail),
      .credit      (credit_in[i]),
      .avail       (ovc_avail[i]),
      .full        (ovc_full[i]),
      .nearly_full (ovc_nearly_full[i]),
      .cnt         (credit_cnt_all[i*CW +: CW]),
      .err_uf      (uf[i]),
      .err_of      (of[i]),
      .err_ill     (ill[i])
    );
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err <= '0;
    else err <= err | {|ill, |of, |uf};
  end
endmodule
